// File: rtl/gpia_wb_slave.sv
// Wishbone B3 classic slave in front of GPIA_DWORD: bus writes become mode/d/stb strobes,
// reads return GPIA state, and the input pins get synchronizing, change flags and an irq.
module gpia_wb_slave #(
  parameter int SYNC_PRIME = 3
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [2:0]  adr_i,
  input  logic [7:0]  sel_i,
  input  logic [63:0] dat_i,
  output logic [63:0] dat_o,
  output logic        ack_o,
  output logic [1:0]  gpia_mode_o,
  output logic [63:0] gpia_d_o,
  output logic [7:0]  gpia_stb_o,
  input  logic [63:0] gpia_q_i,
  input  logic [63:0] pins_i,
  output logic        irq_o
);

  localparam int CNT_W = (SYNC_PRIME < 1) ? 1 : $clog2(SYNC_PRIME + 1);
  localparam logic [CNT_W-1:0] PRIME_MAX = CNT_W'(SYNC_PRIME);

  function automatic logic [63:0] lane_mask(input logic [7:0] sel);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{sel[i]}};
    return m;
  endfunction

  logic             start;
  logic             wr_gpia;
  logic             wr_flags;
  logic             wr_ien;
  logic             rd;
  logic [63:0]      sel_mask;
  logic [63:0]      rd_data;
  logic [63:0]      pins_p0;
  logic [63:0]      pins_p1;
  logic [63:0]      pins_p2;
  logic [63:0]      flags;
  logic [63:0]      flags_clr;
  logic [63:0]      flags_set;
  logic [63:0]      ien;
  logic [CNT_W-1:0] prime_cnt;
  logic             primed;

  // The registered ack blocks a second start on the ack cycle, giving one transfer per 2 cycles.
  assign start    = cyc_i & stb_i & ~ack_o;
  assign wr_gpia  = start & we_i & ~adr_i[2];
  assign wr_flags = start & we_i & (adr_i == 3'd5);
  assign wr_ien   = start & we_i & (adr_i == 3'd6);
  assign rd       = start & ~we_i;
  assign sel_mask = lane_mask(sel_i);

  always_comb begin
    rd_data = '0;
    case (adr_i)
      3'd4:    rd_data = pins_p1;
      3'd5:    rd_data = flags;
      3'd6:    rd_data = ien;
      3'd7:    rd_data = '0;
      default: rd_data = gpia_q_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      ack_o       <= 1'b0;
      dat_o       <= '0;
      gpia_mode_o <= '0;
      gpia_d_o    <= '0;
      gpia_stb_o  <= '0;
      ien         <= '0;
    end else begin
      ack_o      <= start;
      gpia_stb_o <= wr_gpia ? sel_i : 8'h00;
      if (wr_gpia) begin
        gpia_mode_o <= adr_i[1:0];
        gpia_d_o    <= dat_i;
      end
      if (rd) dat_o <= rd_data;
      if (wr_ien) ien <= (ien & ~sel_mask) | (dat_i & sel_mask);
    end
  end

  // Input side: pins_p0/pins_p1 synchronize, pins_p2 is the previous synchronized sample.
  assign primed    = (prime_cnt == PRIME_MAX);
  assign flags_clr = wr_flags ? (dat_i & sel_mask) : '0;
  assign flags_set = primed ? (pins_p1 ^ pins_p2) : '0;

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      pins_p0   <= '0;
      pins_p1   <= '0;
      pins_p2   <= '0;
      flags     <= '0;
      prime_cnt <= '0;
    end else begin
      pins_p0 <= pins_i;
      pins_p1 <= pins_p0;
      pins_p2 <= pins_p1;
      // A change arriving on the same edge as a clear must survive it.
      flags   <= (flags & ~flags_clr) | flags_set;
      if (prime_cnt < PRIME_MAX) prime_cnt <= prime_cnt + 1'b1;
    end
  end

  assign irq_o = |(flags & ien);

endmodule

// File: tb/tb_gpia_wb_slave.sv
// Randomized bench for gpia_wb_slave against a history-based model of the register map,
// with a small GPIA_DWORD stand-in driving gpia_q_i.
module tb_gpia_wb_slave;
  localparam int SP = 3;

  logic        clk_i    = 1'b0;
  logic        res_i    = 1'b0;
  logic        cyc_i    = 1'b0;
  logic        stb_i    = 1'b0;
  logic        we_i     = 1'b0;
  logic [2:0]  adr_i    = '0;
  logic [7:0]  sel_i    = '0;
  logic [63:0] dat_i    = '0;
  logic [63:0] pins_i   = '0;
  logic [63:0] gpia_q_i = '0;
  logic [63:0] dat_o;
  logic [63:0] gpia_d_o;
  logic        ack_o;
  logic        irq_o;
  logic [1:0]  gpia_mode_o;
  logic [7:0]  gpia_stb_o;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Model state: what each output must be after the most recent edge.
  logic        m_ack;
  logic [63:0] m_dat, m_d, m_q, m_flags, m_ien;
  logic [1:0]  m_mode;
  logic [7:0]  m_stb;
  int          m_edges;
  logic [63:0] pin_hist[$];

  always #5 clk_i = ~clk_i;

  gpia_wb_slave #(.SYNC_PRIME(SP)) dut (
    .clk_i(clk_i), .res_i(res_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .gpia_mode_o(gpia_mode_o), .gpia_d_o(gpia_d_o), .gpia_stb_o(gpia_stb_o),
    .gpia_q_i(gpia_q_i), .pins_i(pins_i), .irq_o(irq_o)
  );

  function automatic logic [63:0] lanes(input logic [7:0] sel);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = sel[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [63:0] gpia_apply(input logic [63:0] q, input logic [1:0] mode,
                                             input logic [63:0] d, input logic [7:0] sel);
    logic [63:0] m;
    m = lanes(sel);
    case (mode)
      2'b00:   return (q & ~m) | (d & m);
      2'b01:   return q | (d & m);
      2'b10:   return q & ~(d & m);
      default: return q ^ (d & m);
    endcase
  endfunction

  // GPIA_DWORD stand-in: not reset with the slave, so a torn write would stay visible.
  always @(posedge clk_i)
    if (|gpia_stb_o) gpia_q_i <= gpia_apply(gpia_q_i, gpia_mode_o, gpia_d_o, gpia_stb_o);

  // pins_i as sampled on edge k after reset release (k = 1, 2, ...), zero before that.
  function automatic logic [63:0] pin_at(input int k);
    if (k < 1) return '0;
    return pin_hist[k-1];
  endfunction

  task automatic model_reset();
    m_ack = 1'b0; m_dat = '0; m_d = '0; m_mode = '0; m_stb = '0;
    m_flags = '0; m_ien = '0; m_edges = 0;
    pin_hist.delete();
  endtask

  task automatic model_edge();
    logic        st;
    logic [63:0] lm, nf;
    m_edges++;
    pin_hist.push_back(pins_i);
    st = cyc_i & stb_i & ~m_ack;
    lm = lanes(sel_i);
    nf = m_flags;
    if (st && we_i && adr_i == 3'd5) nf = nf & ~(dat_i & lm);
    if (m_edges - 1 >= SP) nf = nf | (pin_at(m_edges - 2) ^ pin_at(m_edges - 3));
    if (st && !we_i) begin
      case (adr_i)
        3'd4:    m_dat = pin_at(m_edges - 2);
        3'd5:    m_dat = m_flags;
        3'd6:    m_dat = m_ien;
        3'd7:    m_dat = '0;
        default: m_dat = m_q;
      endcase
    end
    if (m_stb != 8'h00) m_q = gpia_apply(m_q, m_mode, m_d, m_stb);
    if (st && we_i && adr_i == 3'd6) m_ien = (m_ien & ~lm) | (dat_i & lm);
    m_flags = nf;
    if (st && we_i && adr_i < 3'd4) begin
      m_mode = adr_i[1:0];
      m_d    = dat_i;
      m_stb  = sel_i;
    end else begin
      m_stb = 8'h00;
    end
    m_ack = st;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("ack_o",  64'(ack_o), 64'(m_ack));
      check("dat_o",  dat_o, m_dat);
      check("stb_o",  64'(gpia_stb_o), 64'(m_stb));
      check("mode_o", 64'(gpia_mode_o), 64'(m_mode));
      check("d_o",    gpia_d_o, m_d);
      check("irq_o",  64'(irq_o), 64'(|(m_flags & m_ien)));
    end
  end

  task automatic step();
    @(posedge clk_i);
    if (res_i) model_edge();
    @(negedge clk_i);
  endtask

  task automatic bus(input logic we, input logic [2:0] adr, input logic [7:0] sel,
                     input logic [63:0] dat);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
    step();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  initial begin
    model_reset();
    m_q    = '0;
    pins_i = 64'hFF;
    @(posedge clk_i);
    @(negedge clk_i);
    chk_en = 1'b1;
    check("rst_ack", 64'(ack_o), 64'd0);
    check("rst_stb", 64'(gpia_stb_o), 64'd0);
    check("rst_irq", 64'(irq_o), 64'd0);
    check("rst_dat", dat_o, 64'd0);
    repeat (2) step();
    res_i = 1'b1;
    repeat (6) step();

    bus(1'b0, 3'd4, 8'h00, 64'd0);
    check("pins_rd", dat_o, 64'hFF);
    check("rd_ack", 64'(ack_o), 64'd1);
    step();
    bus(1'b0, 3'd5, 8'h00, 64'd0);
    check("prime_flags", dat_o, 64'd0);
    step();
    bus(1'b0, 3'd0, 8'h00, 64'd0);
    check("q_after_rst", dat_o, 64'd0);
    step();

    bus(1'b1, 3'd0, 8'b0000_1100, 64'h3C3C3C3C3C3C3C3C);
    check("wr_stb", 64'(gpia_stb_o), 64'h0C);
    check("wr_mode", 64'(gpia_mode_o), 64'd0);
    step();
    check("wr_stb_drop", 64'(gpia_stb_o), 64'd0);
    check("wr_ack_drop", 64'(ack_o), 64'd0);
    step();
    bus(1'b0, 3'd0, 8'h00, 64'd0);
    check("wr_readback", dat_o, 64'h000000003C3C0000);
    step();

    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd0;
    for (int i = 0; i < 6; i++) begin
      check("ack_pattern", 64'(ack_o), 64'(i % 2));
      step();
    end
    cyc_i = 1'b0; stb_i = 1'b0;
    repeat (2) step();

    bus(1'b1, 3'd6, 8'hFF, 64'h1);
    step();
    pins_i = pins_i ^ 64'h1;
    repeat (2) step();
    check("irq_early", 64'(irq_o), 64'd0);
    step();
    check("irq_set", 64'(irq_o), 64'd1);
    bus(1'b0, 3'd5, 8'h00, 64'd0);
    check("flags_rd", dat_o, 64'h1);
    step();
    bus(1'b1, 3'd5, 8'h01, 64'h1);
    check("irq_clr", 64'(irq_o), 64'd0);
    step();

    pins_i = pins_i ^ 64'h1;
    repeat (2) step();
    bus(1'b1, 3'd5, 8'h01, 64'h1);
    check("clr_race_irq", 64'(irq_o), 64'd1);
    step();
    bus(1'b0, 3'd5, 8'h00, 64'd0);
    check("clr_race_flag", dat_o, 64'h1);
    step();

    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 3'd0; sel_i = 8'hFF;
    dat_i = 64'hDEAD_BEEF_0123_4567;
    step();
    #2 res_i = 1'b0;
    model_reset();
    #1;
    check("async_ack", 64'(ack_o), 64'd0);
    check("async_stb", 64'(gpia_stb_o), 64'd0);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    repeat (2) step();
    res_i = 1'b1;
    repeat (5) step();
    bus(1'b0, 3'd0, 8'h00, 64'd0);
    check("no_torn_write", dat_o, 64'h000000003C3C0000);
    step();

    for (int c = 0; c < 3000; c++) begin
      cyc_i = ($urandom_range(0, 3) != 0);
      stb_i = ($urandom_range(0, 3) != 0);
      we_i  = 1'($urandom_range(0, 1));
      adr_i = 3'($urandom_range(0, 7));
      sel_i = 8'($urandom);
      dat_i = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0)
        pins_i = pins_i ^ ({$urandom, $urandom} & {$urandom, $urandom});
      step();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
